// File: rtl/code_loader_if.sv
// Stream input and code-memory write port of the BPF code loader.
// master = host/feeder side, slave = the loader itself.
interface code_loader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int IN_WIDTH   = 32
);
  localparam int DATA_WIDTH = 2 * IN_WIDTH;

  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] code_wr_addr;
  logic [DATA_WIDTH-1:0] code_wr_data;
  logic                  code_wr_en;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, code_wr_addr, code_wr_data, code_wr_en
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, code_wr_addr, code_wr_data, code_wr_en
  );
endinterface

// File: rtl/code_loader.sv
// Packs a 32-bit word stream into 64-bit BPF instructions written to code memory from address 0.
// Build option CODE_LOADER_BYTESWAP_EN: byte-reverse each stream word before packing.
//
// state   | meaning
// S_IDLE  | after reset, no load requested
// S_HI    | waiting for the upper word of the next instruction
// S_LO    | waiting for the lower word; its accept issues the write
// S_DRAIN | capacity exceeded, discarding words until in_last
// S_FIN   | load finished, done or error held until next start
module code_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int IN_WIDTH   = 32,
  parameter int MAX_INSTR  = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  code_loader_if.slave        bus,
  output logic                loading_o,
  output logic                done_o,
  output logic                error_o,
  output logic [ADDR_WIDTH:0] instr_count_o
);
  localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(MAX_INSTR);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_DRAIN, S_FIN} state_t;

  state_t                state_q;
  logic                  in_ready_q;
  logic                  wr_en_q;
  logic                  loading_q;
  logic                  done_q;
  logic                  error_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [IN_WIDTH-1:0]   hi_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [IN_WIDTH-1:0]   word_d;
  logic                  accept;

  assign accept = bus.in_valid && in_ready_q;

`ifdef CODE_LOADER_BYTESWAP_EN
  always_comb begin
    word_d = '0;
    for (int b = 0; b < IN_WIDTH/8; b++)
      word_d[8*b +: 8] = bus.in_data[IN_WIDTH-8-8*b +: 8];
  end
`else
  assign word_d = bus.in_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      loading_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      hi_q       <= '0;
      count_q    <= '0;
    end else begin
      wr_en_q <= 1'b0;
      // start wins over a simultaneous accept; that word is dropped
      if (start_i) begin
        state_q    <= S_HI;
        in_ready_q <= 1'b1;
        loading_q  <= 1'b1;
        done_q     <= 1'b0;
        error_q    <= 1'b0;
        count_q    <= '0;
      end else begin
        case (state_q)
          S_HI: if (accept) begin
            if (count_q == MAX_CNT || bus.in_last) begin
              error_q <= 1'b1;
              if (bus.in_last) begin
                state_q    <= S_FIN;
                in_ready_q <= 1'b0;
                loading_q  <= 1'b0;
              end else begin
                state_q <= S_DRAIN;
              end
            end else begin
              hi_q    <= word_d;
              state_q <= S_LO;
            end
          end
          S_LO: if (accept) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= {hi_q, word_d};
            wr_addr_q <= count_q[ADDR_WIDTH-1:0];
            count_q   <= count_q + CNT_ONE;
            if (bus.in_last) begin
              done_q     <= 1'b1;
              state_q    <= S_FIN;
              in_ready_q <= 1'b0;
              loading_q  <= 1'b0;
            end else begin
              state_q <= S_HI;
            end
          end
          S_DRAIN: if (accept && bus.in_last) begin
            state_q    <= S_FIN;
            in_ready_q <= 1'b0;
            loading_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.code_wr_en   = wr_en_q;
  assign bus.code_wr_addr = wr_addr_q;
  assign bus.code_wr_data = wr_data_q;
  assign loading_o        = loading_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign instr_count_o    = count_q;
endmodule

// File: tb/tb_code_loader.sv
// Directed self-checking bench for code_loader; expected data follows CODE_LOADER_BYTESWAP_EN.
module tb_code_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        loading, done, error;
  logic [10:0] instr_count;
  int          checks = 0;
  int          failures = 0;

  logic [9:0]  wa_q[$];
  logic [63:0] wd_q[$];

  code_loader_if #(.ADDR_WIDTH(10), .IN_WIDTH(32)) bus ();

  code_loader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .bus(bus),
    .loading_o(loading), .done_o(done), .error_o(error), .instr_count_o(instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.code_wr_en === 1'b1) begin
      wa_q.push_back(bus.code_wr_addr);
      wd_q.push_back(bus.code_wr_data);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_w(input logic [31:0] w);
`ifdef CODE_LOADER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.code_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b exp=0", bus.code_wr_en); end
    checks++; if (bus.code_wr_addr !== 10'd0) begin failures++; $display("FAIL rst_wr_addr got=%h exp=0", bus.code_wr_addr); end
    checks++; if (bus.code_wr_data !== 64'd0) begin failures++; $display("FAIL rst_wr_data got=%h exp=0", bus.code_wr_data); end
    checks++; if ({loading, done, error} !== 3'b000) begin failures++; $display("FAIL rst_status got=%b exp=000", {loading, done, error}); end
    checks++; if (instr_count !== 11'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", instr_count); end
    rst_n = 1'b1;
    clear_log();
    send_word(32'hDEAD0001, 1'b0);
    send_word(32'hDEAD0002, 1'b1);
    idle(2);
    checks++; if (wa_q.size() != 0) begin failures++; $display("FAIL idle_ignores_valid got=%0d writes exp=0", wa_q.size()); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL idle_in_ready got=%b exp=0", bus.in_ready); end
  endtask

  task automatic test_basic();
    clear_log();
    pulse_start();
    checks++; if ({loading, bus.in_ready, done, error} !== 4'b1100) begin failures++; $display("FAIL start_status got=%b exp=1100", {loading, bus.in_ready, done, error}); end
    send_word(32'h00280000, 1'b0);
    send_word(32'h0000000C, 1'b0);
    checks++; if (bus.code_wr_en !== 1'b1 || bus.code_wr_addr !== 10'd0) begin failures++; $display("FAIL wr_latency got en=%b addr=%0d exp en=1 addr=0", bus.code_wr_en, bus.code_wr_addr); end
    send_word(32'h00150000, 1'b0);
    send_word(32'h00000800, 1'b1);
    checks++; if ({done, error, loading, bus.in_ready} !== 4'b1000) begin failures++; $display("FAIL basic_status got=%b exp=1000", {done, error, loading, bus.in_ready}); end
    checks++; if (instr_count !== 11'd2) begin failures++; $display("FAIL basic_count got=%0d exp=2", instr_count); end
    idle(2);
    checks++; if (wa_q.size() != 2) begin failures++; $display("FAIL basic_nwr got=%0d exp=2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      checks++; if (wa_q[0] !== 10'd0 || wd_q[0] !== {exp_w(32'h00280000), exp_w(32'h0000000C)}) begin failures++; $display("FAIL basic_wr0 got @%0d=%h", wa_q[0], wd_q[0]); end
      checks++; if (wa_q[1] !== 10'd1 || wd_q[1] !== {exp_w(32'h00150000), exp_w(32'h00000800)}) begin failures++; $display("FAIL basic_wr1 got @%0d=%h", wa_q[1], wd_q[1]); end
    end
    checks++; if (bus.code_wr_en !== 1'b0 || bus.code_wr_addr !== 10'd1 || bus.code_wr_data !== {exp_w(32'h00150000), exp_w(32'h00000800)}) begin
      failures++; $display("FAIL hold_wr got en=%b addr=%0d data=%h", bus.code_wr_en, bus.code_wr_addr, bus.code_wr_data); end
  endtask

  task automatic test_back_to_back();
    int bad;
    clear_log();
    pulse_start();
    for (int i = 0; i < 8; i++) send_word(32'hA5000000 + 32'(i), i == 7);
    idle(1);
    checks++; if (wa_q.size() != 4) begin failures++; $display("FAIL b2b_nwr got=%0d exp=4", wa_q.size()); end
    bad = 0;
    for (int j = 0; j < wa_q.size(); j++)
      if (wa_q[j] !== 10'(j) || wd_q[j] !== {exp_w(32'hA5000000 + 32'(2*j)), exp_w(32'hA5000000 + 32'(2*j+1))}) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL b2b_data got=%0d bad writes exp=0", bad); end
    checks++; if ({done, error, instr_count} !== {2'b10, 11'd4}) begin failures++; $display("FAIL b2b_status got done=%b err=%b cnt=%0d exp 1 0 4", done, error, instr_count); end
  endtask

  task automatic test_gaps();
    clear_log();
    pulse_start();
    send_word(32'h11110000, 1'b0);
    idle(2);
    bus.in_last = 1'b1;
    @(negedge clk);
    send_word(32'h22220000, 1'b0);
    checks++; if (done !== 1'b0 || loading !== 1'b1) begin failures++; $display("FAIL gap_last_ignored got done=%b loading=%b exp 0 1", done, loading); end
    send_word(32'h33330000, 1'b0);
    idle(1);
    send_word(32'h44440000, 1'b1);
    idle(1);
    checks++; if (wa_q.size() != 2) begin failures++; $display("FAIL gap_nwr got=%0d exp=2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      checks++; if (wd_q[1] !== {exp_w(32'h33330000), exp_w(32'h44440000)}) begin failures++; $display("FAIL gap_wr1 got=%h", wd_q[1]); end
    end
  endtask

  task automatic test_odd();
    clear_log();
    pulse_start();
    send_word(32'h00000001, 1'b0);
    send_word(32'h00000002, 1'b0);
    send_word(32'h00000003, 1'b1);
    checks++; if ({done, error, loading, bus.in_ready} !== 4'b0100) begin failures++; $display("FAIL odd_status got=%b exp=0100", {done, error, loading, bus.in_ready}); end
    idle(2);
    checks++; if (wa_q.size() != 1 || instr_count !== 11'd1) begin failures++; $display("FAIL odd_writes got=%0d cnt=%0d exp 1 1", wa_q.size(), instr_count); end
  endtask

  task automatic test_overflow(input int nwords);
    int bad;
    clear_log();
    pulse_start();
    for (int k = 0; k < nwords; k++) begin
      send_word(32'h10000000 + 32'(k), k == nwords - 1);
      if (k == 512) begin
        checks++; if ({error, bus.in_ready, loading, done} !== 4'b1110) begin failures++; $display("FAIL drain_status got=%b exp=1110", {error, bus.in_ready, loading, done}); end
      end
    end
    idle(2);
    checks++; if (wa_q.size() != 256) begin failures++; $display("FAIL max_nwr words=%0d got=%0d exp=256", nwords, wa_q.size()); end
    bad = 0;
    for (int j = 0; j < wa_q.size(); j++)
      if (wa_q[j] !== 10'(j) || wd_q[j] !== {exp_w(32'h10000000 + 32'(2*j)), exp_w(32'h10000000 + 32'(2*j+1))}) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL max_data words=%0d got=%0d bad exp=0", nwords, bad); end
    checks++; if (instr_count !== 11'd256) begin failures++; $display("FAIL max_count got=%0d exp=256", instr_count); end
    if (nwords == 512) begin
      checks++; if ({done, error} !== 2'b10) begin failures++; $display("FAIL exact_max got done=%b err=%b exp 1 0", done, error); end
    end else begin
      checks++; if ({done, error, loading} !== 3'b010) begin failures++; $display("FAIL overflow got done=%b err=%b loading=%b exp 0 1 0", done, error, loading); end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    send_word(32'h0A0A0001, 1'b0);
    send_word(32'h0A0A0002, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 32'h0A0A0003; bus.in_last = 1'b0;
    @(negedge clk);
    bus.in_data = 32'h0A0A0004;
    rst_n = 1'b0;
    @(negedge clk);
    idle(1);
    checks++; if (wa_q.size() != 1) begin failures++; $display("FAIL rstmid_nwr got=%0d exp=1", wa_q.size()); end
    checks++; if ({bus.in_ready, bus.code_wr_en, loading, done, error} !== 5'b0 || bus.code_wr_addr !== 10'd0 || bus.code_wr_data !== 64'd0 || instr_count !== 11'd0) begin
      failures++; $display("FAIL rstmid_outputs got rdy=%b en=%b ld=%b dn=%b er=%b addr=%0d data=%h cnt=%0d exp all 0", bus.in_ready, bus.code_wr_en, loading, done, error, bus.code_wr_addr, bus.code_wr_data, instr_count); end
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    pulse_start();
    send_word(32'hB0000001, 1'b0);
    send_word(32'hB0000002, 1'b0);
    send_word(32'hB0000003, 1'b0);
    start = 1'b1;
    send_word(32'hBBBBBBBB, 1'b0);
    start = 1'b0;
    send_word(32'hC0000001, 1'b0);
    send_word(32'hC0000002, 1'b1);
    idle(1);
    checks++; if (wa_q.size() != 2) begin failures++; $display("FAIL restart_nwr got=%0d exp=2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      checks++; if (wa_q[1] !== 10'd0 || wd_q[1] !== {exp_w(32'hC0000001), exp_w(32'hC0000002)}) begin failures++; $display("FAIL restart_wr got @%0d=%h", wa_q[1], wd_q[1]); end
    end
    checks++; if ({done, error, instr_count} !== {2'b10, 11'd1}) begin failures++; $display("FAIL restart_status got done=%b err=%b cnt=%0d exp 1 0 1", done, error, instr_count); end
  endtask

  task automatic test_byteswap();
    logic [63:0] exp;
`ifdef CODE_LOADER_BYTESWAP_EN
    exp = 64'h4433221188776655;
`else
    exp = 64'h1122334455667788;
`endif
    clear_log();
    pulse_start();
    send_word(32'h11223344, 1'b0);
    send_word(32'h55667788, 1'b1);
    checks++; if (bus.code_wr_en !== 1'b1 || bus.code_wr_data !== exp) begin failures++; $display("FAIL byteswap got en=%b data=%h exp 1 %h", bus.code_wr_en, bus.code_wr_data, exp); end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gaps();
    test_odd();
    test_overflow(514);
    test_overflow(512);
    test_reset_mid();
    test_byteswap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
